// File: rtl/axis_seq_pkg.sv
// Shared types and helpers for the axis sequencer.
// The state encoding is kept to one bit so the sequencer state stays a single flop.
package axis_seq_pkg;

    localparam int MAX_AXES = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } axis_seq_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_mask_next.sv
// Purpose: finds the lowest set mask bit at or above bit 0 (first=1) or strictly above cur.
// Latency: combinational. Backpressure: none.
module axis_mask_next
    import axis_seq_pkg::*;
#(
    parameter int N = 3,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] cur,
    input  logic         first,
    output logic [W-1:0] nxt,
    output logic         found
);

    // Scan from the top down so the lowest qualifying bit is the last to win.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_sequencer.sv
// Purpose: issues one increment per enabled axis, lowest index first; optional watchdog under AXIS_SEQ_TIMEOUT_EN.
// Latency: update -> first increment 1 cycle; ready -> next increment or done 1 cycle.
// Backpressure: holds the current axis in WAIT until ready; update aborts and restarts at any time.
module axis_sequencer
    import axis_seq_pkg::*;
#(
    parameter int NUM_AXES       = 3,
    parameter int AXIS_W         = clog2_min1(NUM_AXES),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                update,
    input  logic [NUM_AXES-1:0] axis_mask,
    input  logic                ready,
    output logic                increment,
    output logic [AXIS_W-1:0]   axis,
    output logic                busy,
    output logic                done,
    output logic                timeout
);

    axis_seq_state_t     state;
    logic [NUM_AXES-1:0] mask_q;
    logic [AXIS_W-1:0]   nxt_axis;
    logic                nxt_found;

    // One finder serves both the restart search (fresh mask) and the advance search.
    axis_mask_next #(
        .N (NUM_AXES),
        .W (AXIS_W)
    ) u_next (
        .mask  (update ? axis_mask : mask_q),
        .cur   (axis),
        .first (update),
        .nxt   (nxt_axis),
        .found (nxt_found)
    );

`ifdef AXIS_SEQ_TIMEOUT_EN
    localparam int WD_W = clog2_min1(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wdog;
    logic            timeout_q;

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mask_q    <= '0;
            axis      <= '0;
            increment <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef AXIS_SEQ_TIMEOUT_EN
            wdog      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            increment <= 1'b0;
            done      <= 1'b0;
            if (update) begin
`ifdef AXIS_SEQ_TIMEOUT_EN
                timeout_q <= 1'b0;
                wdog      <= '0;
`endif
                mask_q <= axis_mask;
                if (nxt_found) begin
                    axis      <= nxt_axis;
                    increment <= 1'b1;
                    busy      <= 1'b1;
                    state     <= WAIT;
                end else begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end else if (state == WAIT) begin
                if (ready) begin
`ifdef AXIS_SEQ_TIMEOUT_EN
                    wdog <= '0;
`endif
                    if (nxt_found) begin
                        axis      <= nxt_axis;
                        increment <= 1'b1;
                    end else begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
`ifdef AXIS_SEQ_TIMEOUT_EN
                else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_q <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end else begin
                    wdog <= wdog + 1'b1;
                end
`endif
            end
        end
    end

endmodule
